daq_bram_streamer: RTL and testbench

DAQ_BRAM_STREAMER -- requirements
Module: daq_bram_streamer

---
 rtl/daq_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 57 +++++
 rtl/daq_bram_streamer.sv | 149 ++++++++++++++
 tb/tb_daq_bram_streamer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ capture and readout stages.
package daq_pkg;

  localparam logic [15:0] C_DELIMITER = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } daq_state_e;

  function automatic logic is_delimiter(input logic [15:0] word);
    return word == C_DELIMITER;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry output buffer with fall-through: an arriving word is presented
// immediately when empty and parked only if the consumer stalls.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;
  logic             empty;

  assign empty   = (cnt_q == 2'd0);
  assign count_o = cnt_q;

  always_comb begin
    out_valid_o = in_valid_i | ~empty;
    out_data_o  = '0;
    if (!empty)          out_data_o = mem_q[rd_ptr_q];
    else if (in_valid_i) out_data_o = in_data_i;
    pop  = ~empty & out_ready_i;
    push = in_valid_i & ~(empty & out_ready_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/daq_bram_streamer.sv
// Streams the capture BRAM from address 0 onto AXI-Stream, terminating on the
// delimiter word or the last address, with credit-limited prefetch.
module daq_bram_streamer
  import daq_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH  = 16,
  parameter int unsigned BRAM_ADDR_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [BRAM_ADDR_WIDTH:0]    word_count_o,
  output logic                        bram_portb_clk,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  output logic                        bram_portb_en,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_portb_rddata,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  daq_state_e                  state_q;
  logic                        en_q;
  logic [BRAM_ADDR_WIDTH-1:0]  addr_q;
  logic [BRAM_ADDR_WIDTH-1:0]  nxt_q;
  logic                        rd_valid_q;
  logic                        rd_last_q;
  logic                        busy_q;
  logic                        done_q;
  logic [BRAM_ADDR_WIDTH:0]    wc_q;

  logic [AXIS_TDATA_WIDTH-1:0] sample;
  logic [AXIS_TDATA_WIDTH:0]   buf_out;
  logic [1:0]                  occ;
  logic [2:0]                  pending;
  logic                        rd_term;
  logic                        beat;
  logic                        last_beat;
  logic                        can_issue;

  assign bram_portb_clk  = aclk;
  assign bram_portb_addr = addr_q;
  assign bram_portb_en   = en_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign word_count_o    = wc_q;
  assign m_axis_tlast    = buf_out[AXIS_TDATA_WIDTH];
  assign m_axis_tdata    = buf_out[AXIS_TDATA_WIDTH-1:0];

  always_comb begin
    sample       = {AXIS_TDATA_WIDTH{bram_portb_rddata[15]}};
    sample[15:0] = bram_portb_rddata[15:0];
    rd_term      = rd_valid_q & (is_delimiter(bram_portb_rddata[15:0]) | rd_last_q);
    beat         = m_axis_tvalid & m_axis_tready;
    last_beat    = beat & m_axis_tlast;
    // Credits: buffered + returning + issuing words, net of the beat leaving now.
    pending      = 3'(occ) + 3'(rd_valid_q) + 3'(en_q);
    can_issue    = pending < (3'd2 + 3'(beat));
  end

  axis_skid_buffer #(
    .WIDTH(AXIS_TDATA_WIDTH + 1)
  ) u_skid (
    .clk_i      (aclk),
    .rst_i      (areset),
    .flush_i    (abort_i),
    .in_valid_i (rd_valid_q),
    .in_data_i  ({rd_term, sample}),
    .out_valid_o(m_axis_tvalid),
    .out_data_o (buf_out),
    .out_ready_i(m_axis_tready),
    .count_o    (occ)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      addr_q     <= '0;
      nxt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wc_q       <= '0;
    end else begin
      // A read still in flight behind the terminating word is dropped here.
      rd_valid_q <= en_q & ~rd_term;
      rd_last_q  <= en_q & (addr_q == LAST_ADDR);
      if (beat) wc_q <= wc_q + (BRAM_ADDR_WIDTH+1)'(1);
      if (abort_i) begin
        state_q    <= ST_IDLE;
        en_q       <= 1'b0;
        rd_valid_q <= 1'b0;
        busy_q     <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              state_q <= ST_READ;
              en_q    <= 1'b1;
              addr_q  <= '0;
              nxt_q   <= BRAM_ADDR_WIDTH'(1);
              wc_q    <= '0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          ST_READ: begin
            if (last_beat) begin
              state_q <= ST_DONE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (rd_term) begin
              state_q <= ST_DRAIN;
              en_q    <= 1'b0;
            end else if (can_issue) begin
              en_q   <= 1'b1;
              addr_q <= nxt_q;
              nxt_q  <= nxt_q + BRAM_ADDR_WIDTH'(1);
              if (nxt_q == LAST_ADDR) state_q <= ST_DRAIN;
            end else begin
              en_q <= 1'b0;
            end
          end
          ST_DRAIN: begin
            en_q <= 1'b0;
            if (last_beat) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_bram_streamer.sv
// Self-checking bench for daq_bram_streamer: directed vectors, random
// backpressure, abort, mid-stream reset and full-memory readout.
module tb_daq_bram_streamer;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [AW:0]   word_count_o;
  logic          bram_portb_clk;
  logic [AW-1:0] bram_portb_addr;
  logic          bram_portb_en;
  logic [DW-1:0] bram_portb_rddata = '0;
  logic [TW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;

  daq_bram_streamer #(
    .AXIS_TDATA_WIDTH(TW),
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .word_count_o     (word_count_o),
    .bram_portb_clk   (bram_portb_clk),
    .bram_portb_addr  (bram_portb_addr),
    .bram_portb_en    (bram_portb_en),
    .bram_portb_rddata(bram_portb_rddata),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  logic [15:0] mem [65536];
  always @(posedge bram_portb_clk)
    if (bram_portb_en) bram_portb_rddata <= mem[bram_portb_addr];

  typedef struct packed {
    logic [5:0][15:0] words;
    logic [2:0]       nexp;
    logic [5:0][31:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q [$];
  int          acc_n;
  bit          mon_en;
  bit          prev_stall;
  logic [32:0] prev_beat;
  bit          rdy_random;
  bit          force_lo;
  int          hold_lo;
  int          hold_hi;
  int          cyc;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] w);
    return {{16{w[15]}}, w};
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'h7FFF) w = 16'h0000;
    return w;
  endfunction

  // Reference: words from address 0 up to and including the delimiter, or to the top address.
  task automatic build_expected();
    exp_q.delete();
    for (int a = 0; a < 65536; a++) begin
      logic lst;
      lst = (mem[a] == 16'h7FFF) || (a == 65535);
      exp_q.push_back({lst, sext(mem[a])});
      if (lst) break;
    end
  endtask

  task automatic step();
    if (force_lo)        m_axis_tready = 1'b0;
    else if (rdy_random) m_axis_tready = ($urandom_range(0, 1) == 1) && !(cyc >= hold_lo && cyc < hold_hi);
    else                 m_axis_tready = 1'b1;
    #1;
    if (mon_en) begin
      if (prev_stall)
        check("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, prev_beat}));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat: got data %h beyond expected stream", m_axis_tdata);
        end else begin
          check($sformatf("beat%0d", acc_n), 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q.pop_front()));
        end
        acc_n++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
    cyc++;
    @(negedge aclk);
  endtask

  task automatic latency_start(input string tag);
    logic [31:0] w0;
    w0         = exp_q[0][31:0];
    acc_n      = 0;
    prev_stall = 0;
    mon_en     = 1;
    cyc        = 0;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
    check({tag, "_en_addr"}, 64'({bram_portb_en, bram_portb_addr}), 64'({1'b1, 16'h0000}));
    step();
    check({tag, "_first_beat"}, 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, w0}));
  endtask

  task automatic run_to_done(input string tag, input int exp_n, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done"}, 64'(done_o), 64'(1));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_count"}, 64'(word_count_o), 64'(exp_n));
    check({tag, "_beats"}, 64'(acc_n), 64'(exp_n));
    check({tag, "_missing"}, 64'(exp_q.size()), 64'(0));
    mon_en = 0;
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{words: {16'h0000, 16'h0005, 16'h7FFF, 16'h0003, 16'h0002, 16'h0001}, nexp: 3'd4,
                exp: {32'h0, 32'h0, 32'h00007FFF, 32'h00000003, 32'h00000002, 32'h00000001}};
    vecs[1] = '{words: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000}, nexp: 3'd2,
                exp: {32'h0, 32'h0, 32'h0, 32'h0, 32'h00007FFF, 32'hFFFF8000}};
    vecs[2] = '{words: {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h7FFF}, nexp: 3'd1,
                exp: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00007FFF}};
    vecs[3] = '{words: {16'h0000, 16'h0000, 16'h7FFF, 16'h7FFE, 16'h8001, 16'hFFFF}, nexp: 3'd4,
                exp: {32'h0, 32'h0, 32'h00007FFF, 32'h00007FFE, 32'hFFFF8001, 32'hFFFFFFFF}};
    mon_en = 0; rdy_random = 0; force_lo = 0; hold_lo = 0; hold_hi = 0; cyc = 0; acc_n = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0100;

    // Power-up reset: outputs cleared before any clock edge.
    areset = 1'b1;
    #1;
    check("reset_outputs", 64'({busy_o, done_o, bram_portb_en, m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'(0));
    check("reset_count_addr", 64'({word_count_o, bram_portb_addr}), 64'(0));
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 6; i++) mem[i] = vecs[v].words[i];
      exp_q.delete();
      for (int i = 0; i < int'(vecs[v].nexp); i++) begin
        logic lst;
        lst = (i == int'(vecs[v].nexp) - 1);
        exp_q.push_back({lst, vecs[v].exp[i]});
      end
      rdy_random = 0;
      latency_start($sformatf("vec%0d", v));
      run_to_done($sformatf("vec%0d", v), int'(vecs[v].nexp), 50);
    end

    // 20-word stream under random backpressure with a 10-cycle stall.
    for (int i = 0; i < 19; i++) mem[i] = rand_word();
    mem[19] = 16'h7FFF;
    for (int i = 20; i < 24; i++) mem[i] = rand_word();
    build_expected();
    rdy_random = 1; hold_lo = 6; hold_hi = 16;
    latency_start("bp20");
    run_to_done("bp20", 20, 400);
    hold_lo = 0; hold_hi = 0;

    for (int r = 0; r < 3; r++) begin
      int len;
      len = int'($urandom_range(1, 40));
      for (int i = 0; i < len - 1; i++) mem[i] = rand_word();
      mem[len-1] = 16'h7FFF;
      for (int i = len; i < len + 4; i++) mem[i] = rand_word();
      build_expected();
      latency_start($sformatf("rnd%0d", r));
      run_to_done($sformatf("rnd%0d", r), len, 600);
    end
    rdy_random = 0;

    // Abort after 10 accepted beats, then restart from address 0.
    for (int i = 0; i < 39; i++) mem[i] = rand_word();
    mem[39] = 16'h7FFF;
    build_expected();
    latency_start("abort");
    begin
      int n;
      n = 0;
      while (acc_n < 10 && n < 100) begin
        step();
        n++;
      end
    end
    check("abort_accepted", 64'(acc_n), 64'(10));
    force_lo = 1; abort_i = 1'b1;
    step();
    abort_i = 1'b0; force_lo = 0; mon_en = 0;
    check("abort_state", 64'({m_axis_tvalid, busy_o, done_o, bram_portb_en}), 64'(0));
    step();
    check("abort_quiet", 64'(m_axis_tvalid), 64'(0));
    build_expected();
    latency_start("restart");
    run_to_done("restart", 40, 200);

    // Abort and start together: abort wins.
    build_expected();
    latency_start("both");
    step(); step(); step();
    mon_en = 0;
    abort_i = 1'b1; start_i = 1'b1;
    step();
    abort_i = 1'b0; start_i = 1'b0;
    check("abort_start_prio", 64'({busy_o, done_o, bram_portb_en, m_axis_tvalid}), 64'(0));

    // Asynchronous reset mid-stream.
    build_expected();
    latency_start("rst");
    for (int i = 0; i < 8; i++) step();
    mon_en = 0;
    #2 areset = 1'b1;
    #1;
    check("midrst_outputs", 64'({busy_o, done_o, bram_portb_en, m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'(0));
    check("midrst_count_addr", 64'({word_count_o, bram_portb_addr}), 64'(0));
    @(negedge aclk);
    areset = 1'b0;
    build_expected();
    latency_start("postrst");
    run_to_done("postrst", 40, 200);

    // No delimiter anywhere: full address space.
    for (int i = 0; i < 65536; i++) mem[i] = (i == 32'h7FFF) ? 16'h1234 : 16'(i);
    build_expected();
    latency_start("full");
    run_to_done("full", 65536, 70000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
